osd_wr_sched: RTL
=================

OSD_WR_SCHED -- requirements
Module: osd_wr_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: OSD write address width.
REQ-002 SHALL have parameter DATA_W, default 32: OSD write data width.
REQ-003 SHALL have parameter BURST_MAX, default 16: maximum consecutive beats per grant, range 1..256.
REQ-004 SHALL have port VID_CLK_I  in  1: the single clock; all logic is in this domain.
REQ-005 SHALL have port VID_RST_I  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port VS_I  in  1: frame sync, positive polarity, synchronous to VID_CLK_I.
REQ-007 SHALL have ports REQ0_VALID_I / REQ1_VALID_I  in  1: requester write valid.
REQ-008 SHALL have ports REQ0_ADDR_I / REQ1_ADDR_I  in  ADDR_W: requester write address.
REQ-009 SHALL have ports REQ0_DATA_I / REQ1_DATA_I  in  DATA_W: requester write data.
REQ-010 SHALL have ports REQ0_READY_O / REQ1_READY_O  out  1: beat accepted when VALID and READY are both high.
REQ-011 SHALL have ports CFG_X_I, CFG_Y_I, CFG_H_I, CFG_V_I  in  16 each: staged OSD window.
REQ-012 SHALL have ports CFG_EN_I, CFG_TRANSPARENT_I  in  1: staged enable and transparency.
REQ-013 SHALL have port CFG_COMMIT_I  in  1: single-cycle pulse that captures the staged configuration.
REQ-014 SHALL have ports OSD_WADDR_O  out  ADDR_W, OSD_WDATA_O  out  DATA_W, OSD_WREQ_O  out  1: OSD write port.
REQ-015 SHALL have ports OSD_X_O, OSD_Y_O, OSD_H_O, OSD_V_O  out  16, OSD_ENABLE_O, OSD_TRANSPARENT_O  out  1: active configuration.
REQ-016 SHALL have port CFG_PENDING_O  out  1: a committed configuration is waiting for the next VS rise.

Function
REQ-017 SHALL use an arbiter FSM with states IDLE, GNT0, GNT1; REQn_READY_O = (state == GNTn), decoded from registered state only.
REQ-018 SHALL move from IDLE to GNTn one cycle after REQn_VALID_I is high; if both are high, SHALL grant the requester not served last (last_served resets to 1, so REQ0 wins first).
REQ-019 SHALL register each accepted beat: OSD_WREQ_O=1 with the beat's address and data exactly 1 cycle after the handshake; otherwise OSD_WREQ_O=0 and address/data hold their last value.
REQ-020 SHALL count accepted beats per grant in an 8-bit counter cleared on each grant entry.
REQ-021 SHALL end a grant when VALID is low in GNTn, or when the BURST_MAX-th beat is accepted.
REQ-022 On grant end, SHALL go directly to the other GNT state if the other requester's VALID is high, else to IDLE; last_served SHALL update to n.
REQ-023 With BURST_MAX=1, two continuously valid requesters SHALL alternate beats with no idle cycle.
REQ-024 SHALL capture all CFG_* inputs into shadow registers on CFG_COMMIT_I and set CFG_PENDING_O on the following edge.
REQ-025 SHALL detect the VS rise as VS_I=1 with the registered previous VS=0; when pending, SHALL copy shadow to active outputs and clear pending on that edge.
REQ-026 If a commit coincides with a VS rise, SHALL apply the previous shadow, load the new shadow, and leave pending set.
REQ-027 A commit while pending SHALL overwrite the shadow; only the last commit before a VS rise takes effect.
REQ-028 The arbiter and configuration paths SHALL be independent; VS SHALL NOT gate writes.

Reset
REQ-029 On VID_RST_I, asynchronously and immediately: state=IDLE, READY=0, OSD_WREQ_O=0, OSD_WADDR_O=0, OSD_WDATA_O=0, beat counter=0, last_served=1.
REQ-030 Reset SHALL clear shadow and active configuration to 0 (OSD_ENABLE_O=0), CFG_PENDING_O=0, and the VS history register to 0.
REQ-031 Reset during a burst SHALL drop the in-flight beat; after release, arbitration restarts from IDLE.

Structure
REQ-032 osd_pkg SHALL hold the state encoding, ADDR_W/DATA_W defaults, and the 16-bit configuration field width.
REQ-033 Shadow/active registers and VS edge detection SHALL be in sub-module osd_cfg_shadow; the arbiter FSM SHALL be in the top level.

Verification
REQ-034 REQ0 only, 20 contiguous beats (addr 0..19, data 0x11001100+0x00010001*i), BURST_MAX=16 -> 16 writes, one IDLE gap, then 4 writes; order and data exact.
REQ-035 Both requesters continuously valid, BURST_MAX=4 -> first grant REQ0, bursts of 4 alternating with no gap cycle; no beat lost or duplicated.
REQ-036 Commit X=0x20,Y=0x10,H=64,V=64,EN=1 mid-frame -> pending=1, outputs unchanged until the VS rise, then updated and pending=0 on that edge.
REQ-037 Commit on the same cycle as a VS rise, following an earlier commit -> earlier values applied at that VS, new values at the next VS.
REQ-038 Assert VID_RST_I mid-burst -> OSD_WREQ_O and READY low without a clock edge; all outputs 0; REQ0 wins after release.

Source files
------------

// File: rtl/osd_pkg.sv
// Shared definitions for the OSD write scheduler: arbiter state encoding,
// default bus widths and the OSD window configuration payload.
package osd_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CFG_W      = 16;
    localparam int unsigned CNT_W      = 8;

    // Arbiter states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    // OSD window configuration, staged and active copies share this layout
    typedef struct packed {
        logic [CFG_W-1:0] x;
        logic [CFG_W-1:0] y;
        logic [CFG_W-1:0] h;
        logic [CFG_W-1:0] v;
        logic             en;
        logic             transparent;
    } osd_cfg_t;

endpackage

// File: rtl/osd_cfg_shadow.sv
// Double-buffered OSD configuration. A commit pulse loads the shadow copy
// and marks it pending; the next rising edge of vs moves shadow to active.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   vs            frame sync (positive polarity, clk domain)
//   commit        single-cycle capture strobe for cfg_stage
//   cfg_stage     staged configuration inputs
//   cfg_active    configuration currently in effect (registered)
//   pending       a committed configuration awaits the next vs rise
module osd_cfg_shadow
    import osd_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     vs,
    input  logic     commit,
    input  osd_cfg_t cfg_stage,
    output osd_cfg_t cfg_active,
    output logic     pending
);

    logic     vs_d;
    logic     vs_rise;
    osd_cfg_t shadow;

    assign vs_rise = vs & ~vs_d;

    // A commit landing on the vs rise applies the old shadow and keeps the
    // new one pending, since the active copy is loaded from the pre-edge shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d       <= 1'b0;
            shadow     <= '0;
            cfg_active <= '0;
            pending    <= 1'b0;
        end else begin
            vs_d <= vs;
            if (commit) begin
                shadow <= cfg_stage;
            end
            if (vs_rise && pending) begin
                cfg_active <= shadow;
            end
            if (commit) begin
                pending <= 1'b1;
            end else if (vs_rise) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/osd_wr_sched.sv
// OSD write scheduler: two-requester burst arbiter feeding a registered OSD
// write port, plus a vs-synchronised double-buffered window configuration.
// Ports:
//   VID_CLK_I, VID_RST_I           clock, asynchronous active-high reset
//   VS_I                           frame sync
//   REQn_VALID/ADDR/DATA_I         requester write beats
//   REQn_READY_O                   requester beat accept (state decode)
//   CFG_*_I, CFG_COMMIT_I          staged configuration and commit strobe
//   OSD_WADDR/WDATA/WREQ_O         registered OSD write port
//   OSD_X/Y/H/V/ENABLE/TRANSPARENT_O active configuration
//   CFG_PENDING_O                  committed configuration awaiting vs rise
module osd_wr_sched
    import osd_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic              VID_CLK_I,
    input  logic              VID_RST_I,
    input  logic              VS_I,
    input  logic              REQ0_VALID_I,
    input  logic [ADDR_W-1:0] REQ0_ADDR_I,
    input  logic [DATA_W-1:0] REQ0_DATA_I,
    output logic              REQ0_READY_O,
    input  logic              REQ1_VALID_I,
    input  logic [ADDR_W-1:0] REQ1_ADDR_I,
    input  logic [DATA_W-1:0] REQ1_DATA_I,
    output logic              REQ1_READY_O,
    input  logic [CFG_W-1:0]  CFG_X_I,
    input  logic [CFG_W-1:0]  CFG_Y_I,
    input  logic [CFG_W-1:0]  CFG_H_I,
    input  logic [CFG_W-1:0]  CFG_V_I,
    input  logic              CFG_EN_I,
    input  logic              CFG_TRANSPARENT_I,
    input  logic              CFG_COMMIT_I,
    output logic [ADDR_W-1:0] OSD_WADDR_O,
    output logic [DATA_W-1:0] OSD_WDATA_O,
    output logic              OSD_WREQ_O,
    output logic [CFG_W-1:0]  OSD_X_O,
    output logic [CFG_W-1:0]  OSD_Y_O,
    output logic [CFG_W-1:0]  OSD_H_O,
    output logic [CFG_W-1:0]  OSD_V_O,
    output logic              OSD_ENABLE_O,
    output logic              OSD_TRANSPARENT_O,
    output logic              CFG_PENDING_O
);

    // Counter value at which the current beat is the last one of the grant
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_served;
    logic             accept;
    logic             grant_end;

    // ---------------- arbiter: state register ----------------
    always_ff @(posedge VID_CLK_I or posedge VID_RST_I) begin
        if (VID_RST_I) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- arbiter: next state ----------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        grant_end = 1'b0;
        case (state)
            ST_IDLE: begin
                // Tie goes to the requester that was not served last
                if (REQ0_VALID_I && REQ1_VALID_I) begin
                    state_nxt = last_served ? ST_GNT0 : ST_GNT1;
                end else if (REQ0_VALID_I) begin
                    state_nxt = ST_GNT0;
                end else if (REQ1_VALID_I) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                accept = REQ0_VALID_I;
                if (!REQ0_VALID_I || (beat_cnt == LAST_BEAT)) begin
                    grant_end = 1'b1;
                    state_nxt = REQ1_VALID_I ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                accept = REQ1_VALID_I;
                if (!REQ1_VALID_I || (beat_cnt == LAST_BEAT)) begin
                    grant_end = 1'b1;
                    state_nxt = REQ0_VALID_I ? ST_GNT0 : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign REQ0_READY_O = (state == ST_GNT0);
    assign REQ1_READY_O = (state == ST_GNT1);

    // Beats accepted in the current grant; zero on every grant entry
    always_ff @(posedge VID_CLK_I or posedge VID_RST_I) begin
        if (VID_RST_I) begin
            beat_cnt <= '0;
        end else if (grant_end || (state == ST_IDLE)) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Fairness memory: 1 means requester 1 was served last
    always_ff @(posedge VID_CLK_I or posedge VID_RST_I) begin
        if (VID_RST_I) begin
            last_served <= 1'b1;
        end else if (grant_end) begin
            last_served <= (state == ST_GNT1);
        end
    end

    // Registered OSD write port; address/data hold between beats
    always_ff @(posedge VID_CLK_I or posedge VID_RST_I) begin
        if (VID_RST_I) begin
            OSD_WREQ_O  <= 1'b0;
            OSD_WADDR_O <= '0;
            OSD_WDATA_O <= '0;
        end else begin
            OSD_WREQ_O <= accept;
            if (accept) begin
                OSD_WADDR_O <= (state == ST_GNT1) ? REQ1_ADDR_I : REQ0_ADDR_I;
                OSD_WDATA_O <= (state == ST_GNT1) ? REQ1_DATA_I : REQ0_DATA_I;
            end
        end
    end

    // ---------------- configuration path ----------------
    osd_cfg_t cfg_stage;
    osd_cfg_t cfg_active;

    assign cfg_stage = '{
        x:           CFG_X_I,
        y:           CFG_Y_I,
        h:           CFG_H_I,
        v:           CFG_V_I,
        en:          CFG_EN_I,
        transparent: CFG_TRANSPARENT_I
    };

    osd_cfg_shadow u_cfg_shadow (
        .clk        (VID_CLK_I),
        .rst        (VID_RST_I),
        .vs         (VS_I),
        .commit     (CFG_COMMIT_I),
        .cfg_stage  (cfg_stage),
        .cfg_active (cfg_active),
        .pending    (CFG_PENDING_O)
    );

    assign OSD_X_O           = cfg_active.x;
    assign OSD_Y_O           = cfg_active.y;
    assign OSD_H_O           = cfg_active.h;
    assign OSD_V_O           = cfg_active.v;
    assign OSD_ENABLE_O      = cfg_active.en;
    assign OSD_TRANSPARENT_O = cfg_active.transparent;

endmodule
